// File: rtl/iob_tdp_ram_arb.sv
// Round-robin arbiter sharing one true-dual-port RAM between N_REQ requesters.
// Grants up to two requests per cycle (port A, then port B) and avoids same-address write hazards.
module iob_tdp_ram_arb #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 11
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ-1:0]         req_we_i,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic [N_REQ-1:0]         resp_valid_o,
    output logic [N_REQ*DATA_W-1:0]  resp_rdata_o,
    output logic                     ram_en_a_o,
    output logic                     ram_we_a_o,
    output logic [ADDR_W-1:0]        ram_addr_a_o,
    output logic [DATA_W-1:0]        ram_data_a_o,
    input  logic [DATA_W-1:0]        ram_q_a_i,
    output logic                     ram_en_b_o,
    output logic                     ram_we_b_o,
    output logic [ADDR_W-1:0]        ram_addr_b_o,
    output logic [DATA_W-1:0]        ram_data_b_o,
    input  logic [DATA_W-1:0]        ram_q_b_i
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] rr_q, rr_d;
    logic [N_REQ-1:0] resp_vld_q, resp_vld_d;
    logic [N_REQ-1:0] tag_q, tag_d;  // 0 = served by port A, 1 = port B

    logic             a_found, b_found;
    logic [PTR_W-1:0] a_idx, b_idx, scan_idx;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input logic [PTR_W:0]   off);
        logic [PTR_W:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= (PTR_W+1)'(N_REQ)) sum = sum - (PTR_W+1)'(N_REQ);
        return sum[PTR_W-1:0];
    endfunction

    // Priority scan from rr_q; port B skips candidates that would collide with port A.
    always_comb begin
        a_found  = 1'b0;
        b_found  = 1'b0;
        a_idx    = '0;
        b_idx    = '0;
        scan_idx = '0;
        if (!rst_i) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                scan_idx = wrap_add(rr_q, (PTR_W+1)'(k));
                if (req_valid_i[scan_idx]) begin
                    if (!a_found) begin
                        a_found = 1'b1;
                        a_idx   = scan_idx;
                    end else if (!b_found &&
                                 !((req_addr_i[scan_idx*ADDR_W +: ADDR_W] ==
                                    req_addr_i[a_idx*ADDR_W +: ADDR_W]) &&
                                   (req_we_i[scan_idx] || req_we_i[a_idx]))) begin
                        b_found = 1'b1;
                        b_idx   = scan_idx;
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready_o  = '0;
        ram_en_a_o   = a_found;
        ram_we_a_o   = 1'b0;
        ram_addr_a_o = '0;
        ram_data_a_o = '0;
        ram_en_b_o   = b_found;
        ram_we_b_o   = 1'b0;
        ram_addr_b_o = '0;
        ram_data_b_o = '0;
        if (a_found) begin
            req_ready_o[a_idx] = 1'b1;
            ram_we_a_o         = req_we_i[a_idx];
            ram_addr_a_o       = req_addr_i[a_idx*ADDR_W +: ADDR_W];
            ram_data_a_o       = req_wdata_i[a_idx*DATA_W +: DATA_W];
        end
        if (b_found) begin
            req_ready_o[b_idx] = 1'b1;
            ram_we_b_o         = req_we_i[b_idx];
            ram_addr_b_o       = req_addr_i[b_idx*ADDR_W +: ADDR_W];
            ram_data_b_o       = req_wdata_i[b_idx*DATA_W +: DATA_W];
        end
    end

    // Pointer advances past the last index granted in scan order.
    always_comb begin
        rr_d       = rr_q;
        resp_vld_d = '0;
        tag_d      = tag_q;
        if (b_found)      rr_d = wrap_add(b_idx, (PTR_W+1)'(1));
        else if (a_found) rr_d = wrap_add(a_idx, (PTR_W+1)'(1));
        if (a_found && !req_we_i[a_idx]) begin
            resp_vld_d[a_idx] = 1'b1;
            tag_d[a_idx]      = 1'b0;
        end
        if (b_found && !req_we_i[b_idx]) begin
            resp_vld_d[b_idx] = 1'b1;
            tag_d[b_idx]      = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            resp_vld_q <= '0;
            tag_q      <= '0;
        end else begin
            rr_q       <= rr_d;
            resp_vld_q <= resp_vld_d;
            tag_q      <= tag_d;
        end
    end

    // A response pending when reset arrives is dropped immediately.
    always_comb begin
        resp_valid_o = rst_i ? '0 : resp_vld_q;
        resp_rdata_o = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (resp_valid_o[i])
                resp_rdata_o[i*DATA_W +: DATA_W] = tag_q[i] ? ram_q_b_i : ram_q_a_i;
        end
    end

endmodule

// File: tb/tb_iob_tdp_ram_arb.sv
// Directed bench for iob_tdp_ram_arb with a behavioural dual-port RAM and a response scoreboard.
module tb_iob_tdp_ram_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 11;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_we, req_ready, resp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata, resp_rdata;
    logic            en_a, we_a, en_b, we_b;
    logic [AW-1:0]   addr_a, addr_b;
    logic [DW-1:0]   data_a, data_b, q_a, q_b;

    logic [DW-1:0]   mem [0:(1<<AW)-1];
    logic            pre_we;
    logic [AW-1:0]   pre_addr;
    logic [DW-1:0]   pre_data;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    iob_tdp_ram_arb #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_ready_o  (req_ready),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .ram_en_a_o   (en_a),
        .ram_we_a_o   (we_a),
        .ram_addr_a_o (addr_a),
        .ram_data_a_o (data_a),
        .ram_q_a_i    (q_a),
        .ram_en_b_o   (en_b),
        .ram_we_b_o   (we_b),
        .ram_addr_b_o (addr_b),
        .ram_data_b_o (data_b),
        .ram_q_b_i    (q_b)
    );

    // Registered-output true-dual-port RAM, plus a backdoor preload port.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (en_a) begin
            if (we_a) mem[addr_a] <= data_a;
            q_a <= mem[addr_a];
        end
        if (en_b) begin
            if (we_b) mem[addr_b] <= data_b;
            q_b <= mem[addr_b];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_a(input string tag, input logic en, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        chk({tag, "_en_a"},   64'(en_a),   64'(en));
        chk({tag, "_we_a"},   64'(we_a),   64'(we));
        chk({tag, "_addr_a"}, 64'(addr_a), 64'(addr));
        chk({tag, "_data_a"}, 64'(data_a), 64'(data));
    endtask

    task automatic chk_b(input string tag, input logic en, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        chk({tag, "_en_b"},   64'(en_b),   64'(en));
        chk({tag, "_we_b"},   64'(we_b),   64'(we));
        chk({tag, "_addr_b"}, 64'(addr_b), 64'(addr));
        chk({tag, "_data_b"}, 64'(data_b), 64'(data));
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic setreq(input int i, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] d);
        req_valid[i]            = 1'b1;
        req_we[i]               = we;
        req_addr[i*AW +: AW]    = addr;
        req_wdata[i*DW +: DW]   = d;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Advance to the next negedge and compare responses against everything granted last cycle.
    task automatic tick(input string tag);
        logic [N-1:0]  em;
        logic [DW-1:0] ed [N];
        exp_t          e;
        @(negedge clk);
        em = '0;
        for (int i = 0; i < int'(N); i++) ed[i] = '0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            em[e.idx]  = 1'b1;
            ed[e.idx]  = e.data;
        end
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(em));
        for (int i = 0; i < int'(N); i++)
            chk($sformatf("%s_rdata%0d", tag, i), 64'(resp_rdata[i*DW +: DW]), 64'(ed[i]));
    endtask

    initial begin
        rst    = 1'b1;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        clear_req();
        @(negedge clk);
        preload(11'h010, 32'hCAFEBABE);
        preload(11'h006, 32'h00000066);
        preload(11'h031, 32'h31313131);
        for (int i = 0; i < 4; i++) preload(AW'(32'h40 + i), DW'(32'h400 + i));

        // Reset holds off every grant even with all requests pending
        for (int i = 0; i < int'(N); i++) setreq(i, 1'b0, AW'(i), '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_ready", 64'(req_ready), 64'(0));
            chk("rst_en_a",  64'(en_a),      64'(0));
            chk("rst_en_b",  64'(en_b),      64'(0));
            chk("rst_resp",  64'(resp_valid), 64'(0));
        end
        rst = 1'b0;

        // Single read by requester 2
        clear_req();
        setreq(2, 1'b0, 11'h010, '0);
        #1;
        chk("t2_ready", 64'(req_ready), 64'(4'b0100));
        chk_a("t2", 1'b1, 1'b0, 11'h010, '0);
        chk_b("t2", 1'b0, 1'b0, '0, '0);
        sb.push_back('{2, 32'hCAFEBABE});
        tick("t2");

        // Requester 3 alone brings the pointer back to 0
        clear_req();
        setreq(3, 1'b0, 11'h010, '0);
        #1;
        chk("t2b_ready", 64'(req_ready), 64'(4'b1000));
        sb.push_back('{3, 32'hCAFEBABE});
        tick("t2b");

        // Dual grant: write on A, read on B
        clear_req();
        setreq(0, 1'b1, 11'h005, 32'h00000011);
        setreq(3, 1'b0, 11'h006, '0);
        #1;
        chk("t3_ready", 64'(req_ready), 64'(4'b1001));
        chk_a("t3", 1'b1, 1'b1, 11'h005, 32'h00000011);
        chk_b("t3", 1'b1, 1'b0, 11'h006, '0);
        sb.push_back('{3, 32'h00000066});
        tick("t3");

        // Read back the write; pointer was 0 so requester 0 wins
        clear_req();
        setreq(0, 1'b0, 11'h005, '0);
        #1;
        chk("t3r_ready", 64'(req_ready), 64'(4'b0001));
        sb.push_back('{0, 32'h00000011});
        tick("t3r");

        // Write/read collision: only the write proceeds
        clear_req();
        setreq(1, 1'b1, 11'h020, 32'hDEAD0020);
        setreq(2, 1'b0, 11'h020, '0);
        #1;
        chk("t4_ready", 64'(req_ready), 64'(4'b0010));
        chk_a("t4", 1'b1, 1'b1, 11'h020, 32'hDEAD0020);
        chk_b("t4", 1'b0, 1'b0, '0, '0);
        tick("t4");

        clear_req();
        setreq(2, 1'b0, 11'h020, '0);
        #1;
        chk("t4n_ready", 64'(req_ready), 64'(4'b0100));
        chk_a("t4n", 1'b1, 1'b0, 11'h020, '0);
        sb.push_back('{2, 32'hDEAD0020});
        tick("t4n");

        // Colliding candidate skipped, scan continues to the next one
        clear_req();
        setreq(3, 1'b1, 11'h030, 32'h30303030);
        setreq(0, 1'b0, 11'h030, '0);
        setreq(1, 1'b0, 11'h031, '0);
        #1;
        chk("t4s_ready", 64'(req_ready), 64'(4'b1010));
        chk_a("t4s", 1'b1, 1'b1, 11'h030, 32'h30303030);
        chk_b("t4s", 1'b1, 1'b0, 11'h031, '0);
        sb.push_back('{1, 32'h31313131});
        tick("t4s");

        // Same-address read pair is allowed on both ports
        clear_req();
        setreq(2, 1'b0, 11'h010, '0);
        setreq(3, 1'b0, 11'h010, '0);
        #1;
        chk("trr_ready", 64'(req_ready), 64'(4'b1100));
        chk_b("trr", 1'b1, 1'b0, 11'h010, '0);
        sb.push_back('{2, 32'hCAFEBABE});
        sb.push_back('{3, 32'hCAFEBABE});
        tick("trr");

        // Round-robin with all four requesters continuously reading
        for (int c = 0; c < 4; c++) begin
            clear_req();
            for (int i = 0; i < int'(N); i++) setreq(i, 1'b0, AW'(32'h40 + i), '0);
            #1;
            if (c % 2 == 0) begin
                chk($sformatf("t5_ready%0d", c), 64'(req_ready), 64'(4'b0011));
                chk_a($sformatf("t5_%0d", c), 1'b1, 1'b0, 11'h040, '0);
                chk_b($sformatf("t5_%0d", c), 1'b1, 1'b0, 11'h041, '0);
                sb.push_back('{0, 32'h400});
                sb.push_back('{1, 32'h401});
            end else begin
                chk($sformatf("t5_ready%0d", c), 64'(req_ready), 64'(4'b1100));
                chk_a($sformatf("t5_%0d", c), 1'b1, 1'b0, 11'h042, '0);
                chk_b($sformatf("t5_%0d", c), 1'b1, 1'b0, 11'h043, '0);
                sb.push_back('{2, 32'h402});
                sb.push_back('{3, 32'h403});
            end
            tick($sformatf("t5_%0d", c));
        end

        // Reset in the cycle after a read grant drops the response
        clear_req();
        setreq(0, 1'b0, 11'h010, '0);
        #1;
        chk("t6_ready", 64'(req_ready), 64'(4'b0001));
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < int'(N); i++) setreq(i, 1'b0, AW'(32'h40 + i), '0);
        tick("t6");
        chk("t6_rst_ready", 64'(req_ready), 64'(0));
        chk("t6_rst_en_a",  64'(en_a),      64'(0));
        tick("t6h");
        rst = 1'b0;
        #1;
        chk("t6_after_ready", 64'(req_ready), 64'(4'b0011));
        sb.push_back('{0, 32'h400});
        sb.push_back('{1, 32'h401});
        tick("t6a");

        clear_req();
        tick("idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
